// File: rtl/alu_driver_16bit_if.sv
// Request/response handshake bundle between a command source and alu_driver_16bit.
// The master drives requests and consumes responses; the slave is the driver.
interface alu_driver_16bit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_lo;
    logic [15:0] resp_hi;
    logic        resp_carry;
    logic        resp_zero;
    logic        resp_err;

    modport master (
        output req_valid, req_cmd, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_lo, resp_hi, resp_carry, resp_zero, resp_err
    );

    modport slave (
        input  req_valid, req_cmd, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_lo, resp_hi, resp_carry, resp_zero, resp_err
    );
endinterface

// File: rtl/alu_driver_16bit.sv
// Command sequencer for an external 16-bit ripple ALU: single-cycle logic/arith ops
// plus a 16-iteration shift-add unsigned multiply that borrows the ALU adder.
module alu_driver_16bit #(
    parameter int unsigned WIDTH  = 16,
    parameter logic [2:0]  OP_AND = 3'd0,
    parameter logic [2:0]  OP_OR  = 3'd1,
    parameter logic [2:0]  OP_ADD = 3'd2
) (
    input  logic             clk,
    input  logic             reset,
    alu_driver_16bit_if.slave bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_ainvert,
    output logic             alu_bnegate,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DRV_W = 2 * WIDTH + 6;

    localparam logic [2:0] CMD_AND = 3'd0;
    localparam logic [2:0] CMD_OR  = 3'd1;
    localparam logic [2:0] CMD_ADD = 3'd2;
    localparam logic [2:0] CMD_SUB = 3'd3;
    localparam logic [2:0] CMD_NOR = 3'd4;
    localparam logic [2:0] CMD_MUL = 3'd5;

    // ALU drive packed as {a, b, op, ainvert, bnegate, cin}
    localparam logic [DRV_W-1:0] DRIVE_IDLE = {{(2 * WIDTH){1'b0}}, OP_AND, 3'b000};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       cmd_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] count;
    logic [2*WIDTH-1:0] step_c;

    // One shift-add iteration: add multiplicand when q[0] is set, then shift {carry,acc,q} right
    always_comb begin
        step_c = {1'b0, acc, q[WIDTH-1:1]};
        if (q[0]) begin
            step_c = {alu_cout, alu_result, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_lo    <= '0;
            bus.resp_hi    <= '0;
            bus.resp_carry <= 1'b0;
            bus.resp_zero  <= 1'b0;
            bus.resp_err   <= 1'b0;
            cmd_q          <= '0;
            acc            <= '0;
            q              <= '0;
            count          <= '0;
            {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <= DRIVE_IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cmd_q         <= bus.req_cmd;
                        bus.req_ready <= 1'b0;
                        if (bus.req_cmd == CMD_MUL) begin
                            state <= MUL;
                            acc   <= '0;
                            q     <= bus.req_b;
                            count <= '0;
                            {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <=
                                {{WIDTH{1'b0}}, bus.req_a, OP_ADD, 3'b000};
                        end else begin
                            state <= EXEC;
                            case (bus.req_cmd)
                                CMD_AND: {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <=
                                    {bus.req_a, bus.req_b, OP_AND, 3'b000};
                                CMD_OR:  {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <=
                                    {bus.req_a, bus.req_b, OP_OR, 3'b000};
                                CMD_ADD: {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <=
                                    {bus.req_a, bus.req_b, OP_ADD, 3'b000};
                                CMD_SUB: {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <=
                                    {bus.req_a, bus.req_b, OP_ADD, 3'b011};
                                CMD_NOR: {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <=
                                    {bus.req_a, bus.req_b, OP_AND, 3'b110};
                                default: {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <=
                                    DRIVE_IDLE;
                            endcase
                        end
                    end
                end

                EXEC: begin
                    state          <= DONE;
                    bus.resp_valid <= 1'b1;
                    bus.resp_hi    <= '0;
                    if (cmd_q > CMD_MUL) begin
                        bus.resp_lo    <= '0;
                        bus.resp_carry <= 1'b0;
                        bus.resp_zero  <= 1'b1;
                        bus.resp_err   <= 1'b1;
                    end else begin
                        bus.resp_lo    <= alu_result;
                        bus.resp_carry <= alu_cout;
                        bus.resp_zero  <= (alu_result == '0);
                        bus.resp_err   <= 1'b0;
                    end
                    {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <= DRIVE_IDLE;
                end

                MUL: begin
                    acc   <= step_c[2*WIDTH-1:WIDTH];
                    q     <= step_c[WIDTH-1:0];
                    count <= count + CNT_W'(1);
                    alu_a <= step_c[2*WIDTH-1:WIDTH];
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state          <= DONE;
                        bus.resp_valid <= 1'b1;
                        bus.resp_hi    <= step_c[2*WIDTH-1:WIDTH];
                        bus.resp_lo    <= step_c[WIDTH-1:0];
                        bus.resp_carry <= (step_c[2*WIDTH-1:WIDTH] != '0);
                        bus.resp_zero  <= (step_c == '0);
                        bus.resp_err   <= 1'b0;
                        {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <= DRIVE_IDLE;
                    end
                end

                DONE: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} <= DRIVE_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_driver_16bit.sv
// Directed bench for alu_driver_16bit with a behavioural ripple-ALU model on the ALU side.
module tb_alu_driver_16bit;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_cin, alu_ainvert, alu_bnegate, alu_cout;
    logic [2:0]  alu_op;

    alu_driver_16bit_if bus ();

    alu_driver_16bit dut (
        .clk(clk), .reset(reset), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_ainvert(alu_ainvert), .alu_bnegate(alu_bnegate), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // External ALU: inverters feed both the logic paths and the ripple adder
    logic [15:0] a_eff, b_eff;
    logic [16:0] sum;
    always_comb begin
        a_eff = alu_ainvert ? ~alu_a : alu_a;
        b_eff = alu_bnegate ? ~alu_b : alu_b;
        sum   = {1'b0, a_eff} + {1'b0, b_eff} + {16'd0, alu_cin};
        case (alu_op)
            3'd0:    alu_result = a_eff & b_eff;
            3'd1:    alu_result = a_eff | b_eff;
            3'd2:    alu_result = sum[15:0];
            default: alu_result = 16'h0000;
        endcase
        alu_cout = sum[16];
    end

    typedef struct {
        logic [2:0]  cmd;
        logic [15:0] a, b, lo, hi;
        logic        carry, zero, err;
        int          lat;
        logic [5:0]  ctrl;   // {op, ainvert, bnegate, cin} expected in the first busy cycle
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[14];

    function automatic vec_t mk(logic [2:0] cmd, logic [15:0] a, logic [15:0] b, logic [15:0] lo,
                                logic [15:0] hi, logic carry, logic zero, logic err, int lat,
                                logic [5:0] ctrl);
        vec_t v;
        v.cmd = cmd; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
        v.carry = carry; v.zero = zero; v.err = err; v.lat = lat; v.ctrl = ctrl;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [37:0] drive();
        return {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin};
    endfunction

    // Present a request, check the first busy cycle's ALU drive, measure latency and the response
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int lat;
        logic [31:0] ab;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.req_ready) timeout({tag, "_ready"});
        bus.req_cmd = v.cmd; bus.req_a = v.a; bus.req_b = v.b; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (v.cmd == 3'd5)      ab = {16'h0000, v.a};
        else if (v.cmd > 3'd5)  ab = 32'h0;
        else                    ab = {v.a, v.b};
        check({tag, "_alu_ab"}, 64'({alu_a, alu_b}), 64'(ab));
        check({tag, "_alu_ctrl"}, 64'({alu_op, alu_ainvert, alu_bnegate, alu_cin}), 64'(v.ctrl));
        lat = 1;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.resp_valid) timeout({tag, "_resp"});
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        check({tag, "_lo"}, 64'(bus.resp_lo), 64'(v.lo));
        check({tag, "_hi"}, 64'(bus.resp_hi), 64'(v.hi));
        check({tag, "_flags"}, 64'({bus.resp_carry, bus.resp_zero, bus.resp_err}),
              64'({v.carry, v.zero, v.err}));
        check({tag, "_done_drive_idle"}, 64'(drive()), 64'h0);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check({tag, "_back_to_idle"}, 64'({bus.resp_valid, bus.req_ready}), 64'b01);
    endtask

    initial begin
        vecs[0]  = mk(3'd0, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0, 1'b1, 1'b0, 1'b0, 2,  6'b000_000);
        vecs[1]  = mk(3'd1, 16'hF0F0, 16'h0F00, 16'hFFF0, 16'h0, 1'b0, 1'b0, 1'b0, 2,  6'b001_000);
        vecs[2]  = mk(3'd2, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 1'b0, 1'b0, 1'b0, 2,  6'b010_000);
        vecs[3]  = mk(3'd2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 2,  6'b010_000);
        vecs[4]  = mk(3'd3, 16'h0005, 16'h0005, 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 2,  6'b010_011);
        vecs[5]  = mk(3'd3, 16'h0003, 16'h0005, 16'hFFFE, 16'h0, 1'b0, 1'b0, 1'b0, 2,  6'b010_011);
        vecs[6]  = mk(3'd4, 16'h00FF, 16'h0F0F, 16'hF000, 16'h0, 1'b1, 1'b0, 1'b0, 2,  6'b000_110);
        vecs[7]  = mk(3'd4, 16'hFFFF, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b0, 2,  6'b000_110);
        vecs[8]  = mk(3'd6, 16'h0001, 16'h0002, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b1, 2,  6'b000_000);
        vecs[9]  = mk(3'd7, 16'hAAAA, 16'h5555, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b1, 2,  6'b000_000);
        vecs[10] = mk(3'd5, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b1, 1'b0, 1'b0, 17, 6'b010_000);
        vecs[11] = mk(3'd5, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 17, 6'b010_000);
        vecs[12] = mk(3'd5, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 17, 6'b010_000);
        vecs[13] = mk(3'd5, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 17, 6'b010_000);

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_cmd = 3'd0; bus.req_a = 16'h0; bus.req_b = 16'h0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_handshake", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
        check("reset_resp", 64'({bus.resp_lo, bus.resp_hi, bus.resp_carry, bus.resp_zero, bus.resp_err}), 64'h0);
        check("reset_drive", 64'(drive()), 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Response back-pressure: outputs hold and a second request is ignored
        bus.req_cmd = 3'd0; bus.req_a = 16'hF0F0; bus.req_b = 16'h3C3C; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_cmd = 3'd2; bus.req_a = 16'h1111; bus.req_b = 16'h2222;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d", i),
                  64'({bus.resp_valid, bus.req_ready, bus.resp_lo, bus.resp_carry}),
                  64'({1'b1, 1'b0, 16'h3030, 1'b1}));
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("hold_release", 64'({bus.resp_valid, bus.req_ready}), 64'b01);
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_queue", 64'({bus.resp_valid, bus.req_ready}), 64'b01);

        // Reset arriving at the eighth multiply iteration
        bus.req_cmd = 3'd5; bus.req_a = 16'h1234; bus.req_b = 16'h0010; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_mul_busy", 64'({bus.resp_valid, bus.req_ready}), 64'b00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_mul_reset_handshake", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
        check("mid_mul_reset_resp",
              64'({bus.resp_lo, bus.resp_hi, bus.resp_carry, bus.resp_zero, bus.resp_err}), 64'h0);
        check("mid_mul_reset_drive", 64'(drive()), 64'h0);
        repeat (12) @(posedge clk);
        #1;
        check("mid_mul_no_late_resp", 64'(bus.resp_valid), 64'h0);
        run_vec(vecs[5], "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
